// File: rtl/ps2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_pkg : shared PS/2 frame constants, state/error encodings, parity helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_FRAME   = 2'd1,
      ERR_PARITY  = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } state_e;

   // Frame layout: [0] start, [8:1] data, [9] parity, [10] stop.
   function automatic logic parity_ok(input logic [PS2_FRAME_BITS-1:0] frame);
      return ^frame[PS2_DATA_BITS+1:1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_input_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_input_filter : pin synchroniser, clock glitch filter and falling-edge detect
// Revision: 1.0
// ---------------------------------------------------------------------------
module ps2_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic fall_o,
   output logic data_o
);

   localparam int             CW         = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0]  c_CNT_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic [FILTER_LEN-1:0]  data_dly_q;
   logic [CW-1:0]          cnt_q;
   logic                   fclk_q;
   logic                   fall_q;
   logic                   w_clk_s;
   logic                   w_data_s;

   assign w_clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign w_data_s = data_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         data_dly_q  <= '1;
         cnt_q       <= '0;
         fclk_q      <= 1'b1;
         fall_q      <= 1'b0;
      end else begin
         clk_sync_q[0]  <= ps2_clk_i;
         data_sync_q[0] <= ps2_data_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync_q[i]  <= clk_sync_q[i-1];
            data_sync_q[i] <= data_sync_q[i-1];
         end
         // Data is delayed by the filter depth so it lines up with fall.
         data_dly_q[0] <= w_data_s;
         for (int i = 1; i < FILTER_LEN; i++) begin
            data_dly_q[i] <= data_dly_q[i-1];
         end
         fall_q <= 1'b0;
         if (w_clk_s != fclk_q) begin
            if (cnt_q == c_CNT_LAST) begin
               fclk_q <= w_clk_s;
               cnt_q  <= '0;
               fall_q <= fclk_q;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign fall_o = fall_q;
   assign data_o = data_dly_q[FILTER_LEN-1];

endmodule
`default_nettype wire

// File: rtl/ps2_packet_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_packet_receiver : multi-frame PS/2 receiver with frame checks and watchdog
// Revision: 1.0
// ---------------------------------------------------------------------------
module ps2_packet_receiver
   import ps2_pkg::*;
#(
   parameter  int FRAMES         = 3,
   parameter  int SYNC_STAGES    = 2,
   parameter  int FILTER_LEN     = 4,
   parameter  int TIMEOUT_CYCLES = 5000,
   localparam int BITS           = PS2_FRAME_BITS * FRAMES,
   localparam int CW             = $clog2(BITS + 1)
) (
   input  logic                  FPGAClk,
   input  logic                  rst,
   input  logic                  PS2Clk,
   input  logic                  PS2Data,
   output logic [8*FRAMES-1:0]   data_out,
   output logic                  valid,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [CW-1:0]         count
);

   localparam int            WW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] c_BITS    = CW'(BITS);
   localparam logic [WW-1:0] c_TIMEOUT = WW'(TIMEOUT_CYCLES);

   state_e                      state_q;
   err_e                        err_code_q;
   logic [BITS-1:0]             shift_q;
   logic [BITS-1:0]             shift_d;
   logic [CW-1:0]               count_q;
   logic [CW-1:0]               count_d;
   logic [WW-1:0]               wd_q;
   logic [WW-1:0]               wd_d;
   logic [8*FRAMES-1:0]         data_q;
   logic                        valid_q;
   logic                        err_q;
   logic                        w_fall;
   logic                        w_bit;
   logic                        w_frame_end;
   logic [PS2_FRAME_BITS-1:0]   w_frame;
   logic [8*FRAMES-1:0]         w_bytes;

   ps2_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_filter (
      .clk_i      (FPGAClk),
      .rst_i      (rst),
      .ps2_clk_i  (PS2Clk),
      .ps2_data_i (PS2Data),
      .fall_o     (w_fall),
      .data_o     (w_bit)
   );

   // New bits enter at the MSB, so the frame just completed is always the top 11 bits.
   always_comb begin
      shift_d     = {w_bit, shift_q[BITS-1:1]};
      count_d     = count_q + 1'b1;
      wd_d        = (wd_q == c_TIMEOUT) ? wd_q : wd_q + 1'b1;
      w_frame     = shift_d[BITS-1 -: PS2_FRAME_BITS];
      w_frame_end = 1'b0;
      for (int k = 1; k <= FRAMES; k++) begin
         if (count_d == CW'(k * PS2_FRAME_BITS)) begin
            w_frame_end = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < FRAMES; k++) begin : g_bytes
      assign w_bytes[8*k +: 8] = shift_d[PS2_FRAME_BITS*k + 1 +: PS2_DATA_BITS];
   end

   always_ff @(posedge FPGAClk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         err_code_q <= ERR_NONE;
         shift_q    <= '0;
         count_q    <= '0;
         wd_q       <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               count_q <= '0;
               wd_q    <= '0;
               if (w_fall && !w_bit) begin
                  state_q <= ST_RECV;
                  shift_q <= shift_d;
                  count_q <= CW'(1);
                  wd_q    <= WW'(1);
               end
            end
            ST_RECV: begin
               if (w_fall) begin
                  shift_q <= shift_d;
                  count_q <= count_d;
                  wd_q    <= WW'(1);
                  if (w_frame_end && (w_frame[0] || !w_frame[PS2_FRAME_BITS-1])) begin
                     err_code_q <= ERR_FRAME;
                     err_q      <= 1'b1;
                     state_q    <= ST_ABORT;
                  end else if (w_frame_end && !parity_ok(w_frame)) begin
                     err_code_q <= ERR_PARITY;
                     err_q      <= 1'b1;
                     state_q    <= ST_ABORT;
                  end else if (count_d == c_BITS) begin
                     data_q  <= w_bytes;
                     valid_q <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end else begin
                  wd_q <= wd_d;
                  if (wd_d == c_TIMEOUT) begin
                     err_code_q <= ERR_TIMEOUT;
                     err_q      <= 1'b1;
                     state_q    <= ST_ABORT;
                  end
               end
            end
            ST_DONE: begin
               valid_q <= 1'b0;
               count_q <= '0;
               wd_q    <= '0;
               state_q <= ST_IDLE;
            end
            ST_ABORT: begin
               err_q   <= 1'b0;
               count_q <= '0;
               wd_q    <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_out = data_q;
   assign valid    = valid_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_packet_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_packet_receiver : directed bench for the 3-frame and 1-frame receivers
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ps2_packet_receiver;

   localparam int SYNC = 2;
   localparam int FLT  = 4;
   localparam int TMO  = 5000;
   localparam int HALF = 40;
   localparam int LAT  = SYNC + FLT + 1;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        ps2c = 1'b1;
   logic        ps2d = 1'b1;
   logic        p1c  = 1'b1;
   logic        p1d  = 1'b1;
   logic [23:0] dout;
   logic        valid;
   logic        err;
   logic [1:0]  ecode;
   logic [5:0]  cnt;
   logic [7:0]  dout1;
   logic        valid1;
   logic        err1;
   logic [1:0]  ecode1;
   logic [3:0]  cnt1;

   always #5 clk = ~clk;

   ps2_packet_receiver #(
      .FRAMES(3), .SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .FPGAClk(clk), .rst(rst), .PS2Clk(ps2c), .PS2Data(ps2d),
      .data_out(dout), .valid(valid), .err(err), .err_code(ecode), .count(cnt)
   );

   ps2_packet_receiver #(
      .FRAMES(1), .SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)
   ) dut1 (
      .FPGAClk(clk), .rst(rst), .PS2Clk(p1c), .PS2Data(p1d),
      .data_out(dout1), .valid(valid1), .err(err1), .err_code(ecode1), .count(cnt1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_valid = 0, n_err = 0, n_both = 0, valid_cyc = 0, err_cyc = 0;
   int n_valid1 = 0, n_err1 = 0, valid1_cyc = 0;
   always @(negedge clk) begin
      if (valid) begin n_valid++; valid_cyc = cyc; end
      if (err)   begin n_err++;   err_cyc   = cyc; end
      if (valid && err) n_both++;
      if (valid1) begin n_valid1++; valid1_cyc = cyc; end
      if (err1) n_err1++;
   end

   int n_pass = 0;
   int n_chk  = 0;
   int fall_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input bit badp, input bit bads);
      logic p;
      p = ~^b;
      if (badp) p = ~p;
      return {~bads, p, b, 1'b0};
   endfunction

   // Sends the first n bits of v (bit 0 first); glitch adds a 2-cycle low pulse in each high phase.
   task automatic send_bits(input logic [43:0] v, input int n, input bit glitch, input bit one);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (one) p1d = v[i]; else ps2d = v[i];
         repeat (10) @(negedge clk);
         if (one) p1c = 1'b0; else ps2c = 1'b0;
         fall_cyc = cyc;
         repeat (HALF) @(negedge clk);
         if (one) p1c = 1'b1; else ps2c = 1'b1;
         repeat (10) @(negedge clk);
         if (glitch) begin
            ps2c = 1'b0;
            repeat (2) @(negedge clk);
            ps2c = 1'b1;
         end
         repeat (HALF - 12) @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_data_out", dout, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", ecode, 0);
      chk("rst_count", cnt, 0);
      chk("rst_data_out1", dout1, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Clean E0 F0 75
      send_bits({11'h0, mk(8'h75, 0, 0), mk(8'hF0, 0, 0), mk(8'hE0, 0, 0)}, 33, 0, 0);
      repeat (20) @(negedge clk);
      chk("pkt1_valid_pulses", n_valid, 1);
      chk("pkt1_data_out", dout, 24'h75F0E0);
      chk("pkt1_latency", valid_cyc, fall_cyc + LAT);
      chk("pkt1_no_err", n_err, 0);
      chk("pkt1_count_idle", cnt, 0);

      // 1C with bad parity in the first frame
      send_bits({33'h0, mk(8'h1C, 1, 0)}, 11, 0, 0);
      repeat (20) @(negedge clk);
      chk("par_err_pulses", n_err, 1);
      chk("par_err_code", ecode, 2);
      chk("par_err_time", err_cyc, fall_cyc + LAT);
      chk("par_no_valid", n_valid, 1);
      chk("par_data_kept", dout, 24'h75F0E0);

      // Clean packet after the aborted one
      send_bits({11'h0, mk(8'h56, 0, 0), mk(8'h34, 0, 0), mk(8'h12, 0, 0)}, 33, 0, 0);
      repeat (20) @(negedge clk);
      chk("pkt2_valid_pulses", n_valid, 2);
      chk("pkt2_data_out", dout, 24'h563412);

      // Stop bit 0 in the second frame
      send_bits({11'h0, mk(8'h0F, 0, 0), mk(8'h55, 0, 1), mk(8'hAA, 0, 0)}, 22, 0, 0);
      repeat (20) @(negedge clk);
      chk("stop_err_pulses", n_err, 2);
      chk("stop_err_code", ecode, 1);
      chk("stop_err_time", err_cyc, fall_cyc + LAT);
      chk("stop_data_kept", dout, 24'h563412);
      chk("stop_count_idle", cnt, 0);

      // PS2Clk stalls after 15 bits
      send_bits({11'h0, mk(8'h75, 0, 0), mk(8'hF0, 0, 0), mk(8'hE0, 0, 0)}, 15, 0, 0);
      chk("tmo_count_mid", cnt, 15);
      for (int i = 0; i < TMO + 1000 && n_err == 2; i++) @(negedge clk);
      chk("tmo_err_pulses", n_err, 3);
      chk("tmo_err_time", err_cyc, fall_cyc + LAT - 1 + TMO);
      chk("tmo_err_code", ecode, 3);
      repeat (3) @(negedge clk);
      chk("tmo_count_idle", cnt, 0);
      chk("tmo_no_valid", n_valid, 2);

      // Glitchy clock, then reset at bit 20
      send_bits({11'h0, mk(8'h33, 0, 0), mk(8'h22, 0, 0), mk(8'h11, 0, 0)}, 20, 1, 0);
      chk("glitch_count", cnt, 20);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("mrst_data_out", dout, 0);
      chk("mrst_count", cnt, 0);
      chk("mrst_err_code", ecode, 0);
      chk("mrst_valid", valid, 0);
      chk("mrst_err", err, 0);
      repeat (5) @(negedge clk);
      send_bits({11'h0, mk(8'hDE, 0, 0), mk(8'hBC, 0, 0), mk(8'h9A, 0, 0)}, 33, 1, 0);
      repeat (20) @(negedge clk);
      chk("pkt3_valid_pulses", n_valid, 3);
      chk("pkt3_data_out", dout, 24'hDEBC9A);
      chk("pkt3_no_err", n_err, 3);

      // Single-frame build
      send_bits({33'h0, mk(8'h5A, 0, 0)}, 11, 0, 1);
      repeat (20) @(negedge clk);
      chk("f1_valid_pulses", n_valid1, 1);
      chk("f1_data_out", dout1, 8'h5A);
      chk("f1_latency", valid1_cyc, fall_cyc + LAT);
      chk("f1_no_err", n_err1, 0);
      chk("f1_count_idle", cnt1, 0);
      chk("f1_err_code", ecode1, 0);

      chk("valid_err_overlap", n_both, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
